// File: rtl/mem_subword_ctrl_if.sv
// Load/store request bus between the datapath control FSM and the sub-word
// controller, together with the word-aligned data memory port.
interface mem_subword_ctrl_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  // Requester side: datapath plus data memory.
  modport master (
    output req, wr, size, sext, addr, wdata, mem_rd,
    input  rdata, done, busy, err, mem_adr, mem_wd, mem_we
  );

  // Controller side.
  modport slave (
    input  req, wr, size, sext, addr, wdata, mem_rd,
    output rdata, done, busy, err, mem_adr, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_subword_ctrl.sv
// Byte/halfword/word load-store sequencer in front of a word-aligned memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted
// and zero/sign-extended. Misaligned or out-of-range accesses complete with
// err and never touch memory.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req; request fields are captured on acceptance
// READ  | memory word addressed; load result or RMW source captured
// MERGE | new sub-word lane folded into the captured word
// WRITE | mem_we asserted for exactly this one cycle
// DONE  | done pulse, err valid; req ignored
module mem_subword_ctrl #(
  parameter int SIZE = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_subword_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  state_t      state;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] mem_wd_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;

  logic        misaligned;
  logic        out_of_range;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Alignment check on the incoming request (size 11 behaves as word).
  always_comb begin
    misaligned = 1'b0;
    case (bus.size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.addr[0];
      default: misaligned = (bus.addr[1:0] != 2'b00);
    endcase
  end

  assign out_of_range = (bus.addr[31:2] >= 30'(SIZE));

  // Lane extraction and extension of the read word for loads.
  always_comb begin
    lane_b = bus.mem_rd[7:0];
    case (addr_q[1:0])
      2'd0: lane_b = bus.mem_rd[7:0];
      2'd1: lane_b = bus.mem_rd[15:8];
      2'd2: lane_b = bus.mem_rd[23:16];
      2'd3: lane_b = bus.mem_rd[31:24];
      default: lane_b = bus.mem_rd[7:0];
    endcase
    lane_h = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    case (size_q)
      2'b00:   load_val = sext_q ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
      2'b01:   load_val = sext_q ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      default: load_val = bus.mem_rd;
    endcase
  end

  // Replace the addressed lane of the captured word with the store data.
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0: merged[7:0]   = wdata_q[7:0];
          2'd1: merged[15:8]  = wdata_q[7:0];
          2'd2: merged[23:16] = wdata_q[7:0];
          2'd3: merged[31:24] = wdata_q[7:0];
          default: merged = word_q;
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Sequencer: request capture, state transitions and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      mem_wd_q <= 32'd0;
      rdata_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            wr_q    <= bus.wr;
            size_q  <= bus.size;
            sext_q  <= bus.sext;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            if (misaligned || out_of_range) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= (bus.wr && bus.size[1]) ? WRITE : READ;
            end
          end
        end
        READ: begin
          if (!wr_q) begin
            rdata_q <= load_val;
            done_q  <= 1'b1;
            state   <= DONE;
          end else begin
            word_q <= bus.mem_rd;
            state  <= MERGE;
          end
        end
        MERGE: begin
          mem_wd_q <= merged;
          state    <= WRITE;
        end
        WRITE: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write enable straight from state so reset drops it asynchronously.
  assign bus.mem_we  = (state == WRITE);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.mem_adr = (state == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
  // Word stores bypass MERGE and write the captured store data directly.
  assign bus.mem_wd  = size_q[1] ? wdata_q : mem_wd_q;

endmodule

// File: doc/mem_subword_ctrl.md
# mem_subword_ctrl

Load/store sequencer between the multicycle MIPS datapath/control FSM and the word-aligned data memory. It accepts one byte, halfword or word access per request. It issues word-aligned reads and writes to the data memory. Sub-word stores run as read-modify-write. Loads return an extracted, zero- or sign-extended result. Misaligned accesses are flagged and never reach memory.

## Interface
Parameters:
- SIZE, 64: data memory depth in words. Word index addr[31:2] >= SIZE is out of range.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  access request; sampled only in IDLE
- wr  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- sext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified for sub-word stores
- rdata  out  32  load result; holds until the next load completes
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- err  out  1  valid with done: 1 = misaligned or out of range
- mem_adr  out  32  to data memory: {addr_q[31:2],2'b00}; 0 in IDLE
- mem_wd  out  32  to data memory: merged write word
- mem_we  out  1  to data memory write enable
- mem_rd  in  32  from data memory: combinational read data

## Operation
- On a req accepted in IDLE, the block registers wr, size, sext, addr and wdata as *_q.
- Misaligned means either of:
  - size=01 with addr[0]=1
  - size=10/11 with addr[1:0]!=0
- Out of range means addr[31:2] >= SIZE.
- Lane numbering is little-endian:
  - Byte lane k (k = addr[1:0]) occupies bits 8k+7:8k.
  - Halfword lane h (h = addr[1]) occupies bits 16h+15:16h.
- FSM states are IDLE, READ, MERGE, WRITE and DONE.
  - IDLE: on req, go to DONE with err=1 if misaligned or out of range. Otherwise go to WRITE for a word store and to READ for everything else.
  - READ: mem_adr is driven. For a load, extract the lane, extend it and register it into rdata, then go to DONE. For a sub-word store, register mem_rd into word_q and go to MERGE.
  - MERGE: mem_wd_q = word_q with the addressed lane replaced by wdata_q[7:0] or wdata_q[15:0]. Go to WRITE.
  - WRITE: mem_we=1 for exactly one cycle. mem_wd is wdata_q for a word store and mem_wd_q otherwise. Go to DONE.
  - DONE: done=1 and err is valid. Go to IDLE. req is ignored in this state.
- Extension rules:
  - Byte, sext=1: {{24{b[7]}},b}.
  - Halfword: same pattern with 16 bits.
  - Word: unmodified.
- Stores and error completions do not change rdata.
- mem_we is decoded from state only. It is never asserted in the error path.

## Timing
- Request accepted at edge 0. done is high in the cycle after:
  - edge 1 for an error
  - edge 2 for a load or a word store
  - edge 4 for a sub-word store
- mem_we is high during the cycle before done.
- Minimum request spacing: the next req is accepted in the cycle after done (IDLE).
- req while busy is ignored, not queued.
- Reset values: state IDLE, rdata 0, done 0, busy 0, err 0, mem_we 0, mem_adr 0, mem_wd 0.
- Reset asserted mid-operation:
  - The FSM is forced to IDLE immediately.
  - mem_we falls asynchronously and no partial write occurs after reset.
  - rdata clears to 0.
- Input changes after acceptance have no effect, because the *_q registers are used throughout.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x10, then load word from 0x10. Required: done at +2 both times, rdata=0xDEADBEEF, err=0.
- Sub-word load extension: memory[4]=0x80FF7F01.
  - lb 0x13 gives 0xFFFFFF80.
  - lbu 0x13 gives 0x00000080.
  - lh 0x12 gives 0xFFFF80FF.
  - lhu 0x10 gives 0x00007F01.
- Byte/half store RMW: memory[2]=0x11223344.
  - sb 0xAA at 0x09 gives 0x1122AA44, with done at +4.
  - sh 0xBEEF at 0x0A then gives 0xBEEFAA44.
- Errors:
  - lh at 0x05: done at +1, err=1, rdata unchanged.
  - sw at 0x0E: done at +1, err=1, mem_we never 1, memory unchanged.
  - lw at 0x100 (SIZE=64): done at +1, err=1.
- Busy handling: assert req with a different address throughout a sub-word store. Only the first request executes. The second is accepted only after DONE.
- Reset mid-RMW: drop rst_n during MERGE. Required: mem_we stays 0, memory word unchanged, and all outputs read reset values.
